// File: rtl/bitfusion_mac_if.sv
// Beat and result channels of the fusible-precision MAC.
// The master drives operands and result acceptance; the slave is the MAC itself.
interface bitfusion_mac_if #(
    parameter int unsigned ACC_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic [31:0]      weight_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] psum;
    logic             ovf;

    modport master (
        output in_valid, in_data, weight_data, out_ready,
        input  in_ready, out_valid, psum, ovf
    );

    modport slave (
        input  in_valid, in_data, weight_data, out_ready,
        output in_ready, out_valid, psum, ovf
    );
endinterface

// File: rtl/bitfusion_mac.sv
// Fusible-precision multiply-accumulate engine.
// Each beat carries 64/(a*b) lanes; lane products are registered in stage 1,
// summed and accumulated in stage 2, and the job result is held until consumed.
module bitfusion_mac #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start,
    input  logic [3:0]       cfg_in_width,
    input  logic [3:0]       cfg_weight_width,
    input  logic             cfg_s_in,
    input  logic             cfg_s_weight,
    input  logic [CNT_W-1:0] cfg_len,
    output logic             cfg_err,
    output logic             busy,
    bitfusion_mac_if.slave   bus
);
    localparam int unsigned Lanes = 16;
    localparam int unsigned ProdW = 18;
    localparam int unsigned SumW  = 20;
    // Wide enough to hold acc plus any beat sum exactly, so overflow is judged on true values.
    localparam int unsigned WideW = ((ACC_W > SumW) ? ACC_W : SumW) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              a_q, b_q;
    logic                    s_in_q, s_w_q;
    logic [CNT_W-1:0]        len_q, cnt_q;
    logic                    cfg_err_q;
    logic                    s1_valid_q;
    logic signed [ProdW-1:0] prod_q [Lanes];
    logic signed [ProdW-1:0] prod_d [Lanes];
    logic [ACC_W-1:0]        acc_q;
    logic                    ovf_q;

    logic                    cfg_ok, start_ok, start_bad, accept, last_beat;
    logic [7:0]              ab;
    int unsigned             n_lanes;
    logic signed [SumW-1:0]  beat_sum;
    logic signed [WideW-1:0] wide;
    logic [ACC_W-1:0]        acc_add;
    logic                    add_ovf;

    function automatic logic legal_width(input logic [3:0] w);
        return (w == 4'd2) || (w == 4'd4) || (w == 4'd8);
    endfunction

    // Extracts lane k of width w and sign/zero-extends it to 9 bits.
    function automatic logic signed [8:0] lane_op(input logic [31:0] data, input int unsigned k,
                                                  input logic [3:0] w, input logic sgn);
        logic [7:0] f;
        f = 8'(data >> (k * w));
        case (w)
            4'd2:    return {{7{sgn & f[1]}}, f[1:0]};
            4'd4:    return {{5{sgn & f[3]}}, f[3:0]};
            default: return {sgn & f[7], f};
        endcase
    endfunction

    assign cfg_ok    = legal_width(cfg_in_width) && legal_width(cfg_weight_width);
    assign start_ok  = (state_q == StIdle) && start && cfg_ok;
    assign start_bad = (state_q == StIdle) && start && !cfg_ok;
    assign accept    = bus.in_valid && bus.in_ready;
    assign last_beat = (cnt_q + CNT_W'(1)) == len_q;
    assign ab        = 8'(a_q) * 8'(b_q);

    // Lane count follows the 64-bit brick budget.
    always_comb begin
        case (ab)
            8'd4:    n_lanes = 16;
            8'd8:    n_lanes = 8;
            8'd16:   n_lanes = 4;
            8'd32:   n_lanes = 2;
            default: n_lanes = 1;
        endcase
    end

    // Stage 1 input: per-lane products, zero for lanes beyond the active count.
    always_comb begin
        for (int unsigned k = 0; k < Lanes; k++) begin
            if (k < n_lanes) begin
                prod_d[k] = ProdW'(lane_op(bus.in_data, k, a_q, s_in_q)) *
                            ProdW'(lane_op(bus.weight_data, k, b_q, s_w_q));
            end else begin
                prod_d[k] = '0;
            end
        end
    end

    // Stage 2 input: lane sum added to acc with signed overflow detection.
    always_comb begin
        beat_sum = '0;
        for (int unsigned k = 0; k < Lanes; k++) begin
            beat_sum = beat_sum + SumW'(prod_q[k]);
        end
        wide    = WideW'(signed'(acc_q)) + WideW'(beat_sum);
        acc_add = wide[ACC_W-1:0];
        add_ovf = wide != WideW'(signed'(wide[ACC_W-1:0]));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; clear overrides everything.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (start_ok) state_d = (cfg_len == '0) ? StDone : StRun;
                StRun:   if (accept && last_beat) state_d = StDrain;
                StDrain: if (!s1_valid_q) state_d = StDone;
                StDone:  if (bus.out_ready) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs; psum is only exposed while the result is offered.
    always_comb begin
        busy          = state_q != StIdle;
        bus.in_ready  = state_q == StRun;
        bus.out_valid = state_q == StDone;
        bus.psum      = (state_q == StDone) ? acc_q : '0;
        bus.ovf       = ovf_q;
        cfg_err       = cfg_err_q;
    end

    // Config latch, beat counter, product pipeline and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            s_in_q     <= 1'b0;
            s_w_q      <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            cfg_err_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            for (int unsigned k = 0; k < Lanes; k++) prod_q[k] <= '0;
        end else if (clear) begin
            cnt_q      <= '0;
            cfg_err_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            for (int unsigned k = 0; k < Lanes; k++) prod_q[k] <= '0;
        end else begin
            cfg_err_q  <= start_bad;
            s1_valid_q <= accept;
            if (accept) begin
                for (int unsigned k = 0; k < Lanes; k++) prod_q[k] <= prod_d[k];
            end
            if (start_ok) begin
                a_q    <= cfg_in_width;
                b_q    <= cfg_weight_width;
                s_in_q <= cfg_s_in;
                s_w_q  <= cfg_s_weight;
                len_q  <= cfg_len;
                cnt_q  <= '0;
                acc_q  <= '0;
                ovf_q  <= 1'b0;
            end else begin
                if (accept) cnt_q <= cnt_q + CNT_W'(1);
                if (s1_valid_q) begin
                    acc_q <= acc_add;
                    ovf_q <= ovf_q | add_ovf;
                end
            end
        end
    end
endmodule
